leopard_linebuf: RTL and testbench

Double-buffered scanline buffer sitting between the pixel source and the VGA output pins, directly downstream of the raster timing generator. It accepts one line of 12-bit RGB pixels per scanline over a valid/ready stream into a back bank, swaps banks at each horizontal blanking start, and replays the front bank indexed by the timing generator's `x`. Sync and blank signals are delayed to match the read latency, so the outputs drive the 4:4:4 DAC pins directly.

---
 rtl/leopard_linebuf.sv | 186 ++++++++++++++++++
 tb/tb_leopard_linebuf.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/leopard_linebuf.sv
// Double-buffered 12-bit RGB scanline buffer: fills a back bank from a valid/ready stream and replays the front bank 2 cycles behind the raster timing.
// Optional LEOPARD_LINEBUF_PATTERN_EN: show an x/y test pattern when no fresh line is available.
module leopard_linebuf #(
    parameter int WIDTH_PX = 640,
    parameter int ADDR_W   = 10
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [11:0] s_data,
    input  logic        s_last,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_hblank,
    input  logic        in_vblank,
    input  logic [11:0] in_x,
    input  logic [11:0] in_y,
    output logic        hsync,
    output logic        vsync,
    output logic        hblank,
    output logic        vblank,
    output logic [3:0]  datar,
    output logic [3:0]  datag,
    output logic [3:0]  datab,
    output logic        underrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH_PX - 1);
    localparam logic [11:0]       X_LIMIT   = 12'(WIDTH_PX);

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } wr_state_e;

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic              wr_bank_q, wr_bank_d;
    logic              front_valid_q, front_valid_d;
    logic              fallback_q, fallback_d;
    logic              underrun_q, underrun_d;

    logic              hsync1_q, vsync1_q, hblank1_q, vblank1_q;
    logic [11:0]       x1_q;
    logic              hsync_q, vsync_q, hblank_q, vblank_q;
    logic [11:0]       pix_q, pix_d;
    logic [11:0]       rd_word_q;
    logic [ADDR_W-1:0] rd_addr;
    logic              hs;
    logic              swap_ev;
    logic              visible;

    logic [11:0] bank0_mem [WIDTH_PX];
    logic [11:0] bank1_mem [WIDTH_PX];

`ifdef LEOPARD_LINEBUF_PATTERN_EN
    logic [11:0] y1_q;
    logic [11:0] pattern;
`else
    logic        unused_in_y;
    assign unused_in_y = ^in_y;
`endif

    assign s_ready = (state_q == FILL) && !areset;
    assign hs      = s_valid && s_ready;
    // hblank1_q doubles as the previous-hblank register for edge detection.
    assign swap_ev = in_hblank && !hblank1_q;
    assign rd_addr = (in_x[ADDR_W-1:0] <= LAST_ADDR) ? in_x[ADDR_W-1:0] : '0;
    assign visible = !(hblank1_q || vblank1_q) && (x1_q < X_LIMIT);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d       = state_q;
        wptr_d        = wptr_q;
        wr_bank_d     = wr_bank_q;
        front_valid_d = front_valid_q;
        fallback_d    = fallback_q;
        underrun_d    = 1'b0;

        if (hs) begin
            wptr_d = wptr_q + 1'b1;
            if (s_last || (wptr_q == LAST_ADDR)) begin
                state_d = DONE;
            end
        end

        // Swap decision looks at the pre-edge writer state, so a final handshake
        // landing on the hblank edge still counts as an underrun.
        if (swap_ev) begin
            if (state_q == DONE) begin
                wr_bank_d     = ~wr_bank_q;
                wptr_d        = '0;
                state_d       = FILL;
                front_valid_d = 1'b1;
                fallback_d    = 1'b0;
            end else if (!in_vblank) begin
                underrun_d = 1'b1;
                fallback_d = 1'b1;
            end
        end
    end

`ifdef LEOPARD_LINEBUF_PATTERN_EN
    assign pattern = {x1_q[3:0] ^ y1_q[3:0], x1_q[4:1] ^ y1_q[4:1], x1_q[5:2] ^ y1_q[5:2]};

    always_comb begin
        pix_d = '0;
        if (visible) begin
            pix_d = (fallback_q || !front_valid_q) ? pattern : rd_word_q;
        end
    end
`else
    always_comb begin
        pix_d = '0;
        if (visible && front_valid_q) begin
            pix_d = rd_word_q;
        end
    end
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= FILL;
            wptr_q        <= '0;
            wr_bank_q     <= 1'b0;
            front_valid_q <= 1'b0;
            fallback_q    <= 1'b0;
            underrun_q    <= 1'b0;
            hsync1_q      <= 1'b0;
            vsync1_q      <= 1'b0;
            hblank1_q     <= 1'b0;
            vblank1_q     <= 1'b0;
            x1_q          <= '0;
`ifdef LEOPARD_LINEBUF_PATTERN_EN
            y1_q          <= '0;
`endif
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            pix_q         <= '0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            wr_bank_q     <= wr_bank_d;
            front_valid_q <= front_valid_d;
            fallback_q    <= fallback_d;
            underrun_q    <= underrun_d;
            hsync1_q      <= in_hsync;
            vsync1_q      <= in_vsync;
            hblank1_q     <= in_hblank;
            vblank1_q     <= in_vblank;
            x1_q          <= in_x;
`ifdef LEOPARD_LINEBUF_PATTERN_EN
            y1_q          <= in_y;
`endif
            hsync_q       <= hsync1_q;
            vsync_q       <= vsync1_q;
            hblank_q      <= hblank1_q;
            vblank_q      <= vblank1_q;
            pix_q         <= pix_d;
        end
    end

    // NOTE: bank storage has no reset; front_valid gates its use until a full line lands.
    always_ff @(posedge aclk) begin
        if (hs && !wr_bank_q) begin
            bank0_mem[wptr_q] <= s_data;
        end
        if (hs && wr_bank_q) begin
            bank1_mem[wptr_q] <= s_data;
        end
        rd_word_q <= wr_bank_q ? bank0_mem[rd_addr] : bank1_mem[rd_addr];
    end

    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign hblank   = hblank_q;
    assign vblank   = vblank_q;
    assign datar    = pix_q[11:8];
    assign datag    = pix_q[7:4];
    assign datab    = pix_q[3:0];
    assign underrun = underrun_q;

endmodule

// File: tb/tb_leopard_linebuf.sv
// Directed bench for leopard_linebuf: swap, underrun, short lines, coincident last/hblank, mid-line reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_leopard_linebuf;

    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [11:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        in_hsync = 1'b0;
    logic        in_vsync = 1'b0;
    logic        in_hblank = 1'b0;
    logic        in_vblank = 1'b0;
    logic [11:0] in_x = '0;
    logic [11:0] in_y = '0;
    logic        hsync, vsync, hblank, vblank;
    logic [3:0]  datar, datag, datab;
    logic        underrun;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 aclk = ~aclk;

    leopard_linebuf dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .in_hblank (in_hblank),
        .in_vblank (in_vblank),
        .in_x      (in_x),
        .in_y      (in_y),
        .hsync     (hsync),
        .vsync     (vsync),
        .hblank    (hblank),
        .vblank    (vblank),
        .datar     (datar),
        .datag     (datag),
        .datab     (datab),
        .underrun  (underrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge aclk);
    endtask

    task automatic stream(input int n, input logic [11:0] base, input bit use_last);
        for (int i = 0; i < n; i++) begin
            int budget;
            budget  = 0;
            s_valid = 1'b1;
            s_data  = base + 12'(i);
            s_last  = use_last && (i == n - 1);
            while (!s_ready && budget < 20) begin
                step();
                budget++;
            end
            if (!s_ready) begin
                check("stream_ready_timeout", s_ready, 1);
                break;
            end
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic hblank_edge(input string tag, input logic exp_under);
        in_hblank = 1'b1;
        step();
        check({tag, "_underrun"}, underrun, exp_under);
        in_hblank = 1'b0;
        step();
        check({tag, "_underrun_end"}, underrun, 0);
    endtask

    task automatic read_px(input string tag, input int x, input int y, input logic [11:0] exp);
        in_x = 12'(x);
        in_y = 12'(y);
        step();
        step();
        check(tag, {datar, datag, datab}, exp);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset with sync inputs high: outputs must still be zero.
        areset   = 1'b1;
        in_hsync = 1'b1;
        in_vsync = 1'b1;
        step();
        step();
        check("rst_s_ready", s_ready, 0);
        check("rst_sync", {hsync, vsync, hblank, vblank}, 0);
        check("rst_pix", {datar, datag, datab}, 0);
        check("rst_underrun", underrun, 0);
        areset   = 1'b0;
        in_hsync = 1'b0;
        in_vsync = 1'b0;
        step();
        check("post_rst_s_ready", s_ready, 1);

        // Full line with data = index, swap, replay with 2-cycle alignment.
        stream(640, 12'h000, 1'b0);
        check("t1_done_ready", s_ready, 0);
        hblank_edge("t1_swap", 1'b0);
        check("t1_fill_ready", s_ready, 1);
        in_x     = 12'd5;
        in_y     = 12'd0;
        in_hsync = 1'b1;
        step();
        in_hsync = 1'b0;
        check("t1_hsync_d1", hsync, 0);
        step();
        check("t1_hsync_d2", hsync, 1);
        check("t1_x5", {datar, datag, datab}, 12'h005);
        step();
        check("t1_hsync_d3", hsync, 0);
        read_px("t1_x639", 639, 0, 12'h27F);
        read_px("t1_x640", 640, 0, 12'h000);
        in_vblank = 1'b1;
        read_px("t1_vblank_pix", 5, 0, 12'h000);
        check("t1_vblank_out", vblank, 1);
        in_vblank = 1'b0;

        // No data for a line: underrun, then front line repeats or pattern.
        hblank_edge("t2", 1'b1);
`ifdef LEOPARD_LINEBUF_PATTERN_EN
        read_px("t2_pattern", 3, 1, 12'h210);
`else
        read_px("t2_repeat", 3, 1, 12'h003);
`endif

        // Full line into the other bank; successful swap clears fallback.
        stream(640, 12'h800, 1'b0);
        hblank_edge("t3", 1'b0);
        read_px("t3_x5", 5, 0, 12'h805);
        read_px("t3_x100", 100, 0, 12'h864);

        // Short line with s_last on #99, then back-pressure while DONE.
        stream(100, 12'hA00, 1'b1);
        check("t4_done_ready", s_ready, 0);
        s_valid = 1'b1;
        s_data  = 12'hFFF;
        s_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_hold_ready", s_ready, 0);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        hblank_edge("t4", 1'b0);
        read_px("t4_x99", 99, 0, 12'hA63);
        read_px("t4_x0", 0, 0, 12'hA00);
        read_px("t4_x100_stale", 100, 0, 12'h064);
        read_px("t4_x1000", 1000, 0, 12'h000);

        // Final handshake coincides with the hblank edge: underrun, swap deferred.
        stream(9, 12'h300, 1'b0);
        s_valid   = 1'b1;
        s_data    = 12'h309;
        s_last    = 1'b1;
        in_hblank = 1'b1;
        step();
        s_valid   = 1'b0;
        s_last    = 1'b0;
        check("t5_underrun", underrun, 1);
        in_hblank = 1'b0;
        step();
        check("t5_underrun_end", underrun, 0);
        check("t5_done_ready", s_ready, 0);
`ifdef LEOPARD_LINEBUF_PATTERN_EN
        read_px("t5_no_swap", 5, 0, 12'h521);
`else
        read_px("t5_no_swap", 5, 0, 12'hA05);
`endif
        hblank_edge("t5_swap", 1'b0);
        read_px("t5_x5", 5, 0, 12'h305);
        read_px("t5_x9", 9, 0, 12'h309);

        // Reset after 300 pixels: partial line discarded, output blank until a new full line.
        stream(300, 12'h500, 1'b0);
        areset   = 1'b1;
        in_hsync = 1'b1;
        in_vsync = 1'b1;
        in_x     = 12'd5;
        step();
        check("t6_rst_s_ready", s_ready, 0);
        check("t6_rst_sync", {hsync, vsync, hblank, vblank}, 0);
        check("t6_rst_pix", {datar, datag, datab}, 0);
        check("t6_rst_underrun", underrun, 0);
        areset   = 1'b0;
        in_hsync = 1'b0;
        in_vsync = 1'b0;
        step();
        check("t6_post_rst_ready", s_ready, 1);
`ifdef LEOPARD_LINEBUF_PATTERN_EN
        read_px("t6_pre_line", 5, 0, 12'h521);
`else
        read_px("t6_pre_line", 5, 0, 12'h000);
`endif
        hblank_edge("t6_nodata", 1'b1);
`ifdef LEOPARD_LINEBUF_PATTERN_EN
        read_px("t6_after_underrun", 5, 0, 12'h521);
`else
        read_px("t6_after_underrun", 5, 0, 12'h000);
`endif
        stream(640, 12'h600, 1'b0);
        hblank_edge("t6_swap", 1'b0);
        read_px("t6_x5", 5, 0, 12'h605);
        read_px("t6_x350", 350, 0, 12'h75E);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
